// File: rtl/led_pwm_engine.sv
// led_pwm_engine: register-programmed multi-channel LED PWM driver with group dim/blink; define LED_FADE_EN for duty fading
module led_pwm_engine #(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic [NUM_CH-1:0] leds
);
    typedef logic [PWM_BITS-1:0] duty_t;

    logic              sleep_q, sleep_d, dmblnk_q, dmblnk_d, invrt_q, invrt_d;
    logic [7:0]        grppwm_q, grppwm_d, grpfreq_q, grpfreq_d, fadestep_q, fadestep_d;
    logic [1:0]        ledout_q [NUM_CH];
    logic [1:0]        ledout_d [NUM_CH];
    duty_t             pwm_q [NUM_CH];
    duty_t             pwm_d [NUM_CH];
    duty_t             eff [NUM_CH];
    logic [15:0]       pre_q, pre_d;
    duty_t             cnt_q, cnt_d;
    logic [7:0]        gpre_q, gpre_d, gcnt_q, gcnt_d;
    logic [7:0]        rdata_q, rdata_d, rd_mux;
    logic              rvalid_q;
    logic [NUM_CH-1:0] leds_q, leds_d, leds_raw;
    logic              tick, wrap, gclr, gate;

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign leds   = leds_q;

    // PWM timebase and group counter; all counting freezes while asleep, a DMBLNK change or GRPFREQ write restarts the group
    always_comb begin
        tick   = !sleep_q && pre_q == 16'(PRESCALE - 1);
        wrap   = tick && cnt_q == '1;
        gclr   = wr_en && ((addr == 8'h00 && wdata[3] != dmblnk_q) || addr == 8'h02);
        pre_d  = sleep_q ? pre_q : (tick ? '0 : pre_q + 16'd1);
        cnt_d  = tick ? cnt_q + duty_t'(1) : cnt_q;
        gpre_d = gpre_q;
        gcnt_d = gcnt_q;
        if (wrap) begin
            if (!dmblnk_q || gpre_q == grpfreq_q) begin
                gpre_d = '0;
                gcnt_d = gcnt_q + 8'd1;
            end else begin
                gpre_d = gpre_q + 8'd1;
            end
        end
        if (gclr) begin
            gpre_d = '0;
            gcnt_d = '0;
        end
    end

    // Register file writes; unmapped addresses and reserved bits fall through untouched
    always_comb begin
        sleep_d    = sleep_q;
        dmblnk_d   = dmblnk_q;
        invrt_d    = invrt_q;
        grppwm_d   = grppwm_q;
        grpfreq_d  = grpfreq_q;
        fadestep_d = fadestep_q;
        ledout_d   = ledout_q;
        pwm_d      = pwm_q;
        if (wr_en) begin
            if (addr == 8'h00) {sleep_d, dmblnk_d, invrt_d} = wdata[4:2];
            if (addr == 8'h01) grppwm_d = wdata;
            if (addr == 8'h02) grpfreq_d = wdata;
`ifdef LED_FADE_EN
            if (addr == 8'h03) fadestep_d = wdata;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (addr == 8'(8 + i / 4)) ledout_d[i] = wdata[2*(i%4) +: 2];
                if (addr == 8'(32 + i)) pwm_d[i] = duty_t'(wdata);
            end
        end
    end

`ifdef LED_FADE_EN
    duty_t duty_q [NUM_CH];
    duty_t duty_d [NUM_CH];
    duty_t step;

    // Effective duty slews toward PWMi by FADESTEP per PWM period, landing exactly on target; zero step tracks immediately
    always_comb begin
        step = duty_t'(fadestep_q);
        for (int i = 0; i < NUM_CH; i++) begin
            duty_d[i] = duty_q[i];
            eff[i]    = fadestep_q == 8'h00 ? pwm_q[i] : duty_q[i];
            if (fadestep_q == 8'h00) duty_d[i] = pwm_q[i];
            else if (wrap && pwm_q[i] > duty_q[i]) duty_d[i] = (pwm_q[i] - duty_q[i] <= step) ? pwm_q[i] : duty_q[i] + step;
            else if (wrap) duty_d[i] = (duty_q[i] - pwm_q[i] <= step) ? pwm_q[i] : duty_q[i] - step;
        end
    end

    // Effective duty registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) duty_q <= '{default: '0};
        else          duty_q <= duty_d;
    end
`else
    // Effective duty is the programmed duty
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) eff[i] = pwm_q[i];
    end
`endif

    // Read mux captured on rd_en (pre-write values) and per-channel LED mode selection
    always_comb begin
        rd_mux = 8'h00;
        if (addr == 8'h00) rd_mux = {3'b000, sleep_q, dmblnk_q, invrt_q, 2'b00};
        if (addr == 8'h01) rd_mux = grppwm_q;
        if (addr == 8'h02) rd_mux = grpfreq_q;
        if (addr == 8'h03) rd_mux = fadestep_q;
        gate     = gcnt_q < grppwm_q;
        leds_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == 8'(8 + i / 4)) rd_mux[2*(i%4) +: 2] = ledout_q[i];
            if (addr == 8'(32 + i)) rd_mux = 8'(pwm_q[i]);
            leds_raw[i] = ledout_q[i] == 2'b01 || (ledout_q[i][1] && cnt_q < eff[i] && (!ledout_q[i][0] || gate));
        end
        rdata_d = rd_en ? rd_mux : rdata_q;
        leds_d  = sleep_q ? '0 : leds_raw ^ {NUM_CH{invrt_q}};
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sleep_q    <= 1'b0;
            dmblnk_q   <= 1'b0;
            invrt_q    <= 1'b0;
            grppwm_q   <= '0;
            grpfreq_q  <= '0;
            fadestep_q <= '0;
            ledout_q   <= '{default: '0};
            pwm_q      <= '{default: '0};
            pre_q      <= '0;
            cnt_q      <= '0;
            gpre_q     <= '0;
            gcnt_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            leds_q     <= '0;
        end else begin
            sleep_q    <= sleep_d;
            dmblnk_q   <= dmblnk_d;
            invrt_q    <= invrt_d;
            grppwm_q   <= grppwm_d;
            grpfreq_q  <= grpfreq_d;
            fadestep_q <= fadestep_d;
            ledout_q   <= ledout_d;
            pwm_q      <= pwm_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            gpre_q     <= gpre_d;
            gcnt_q     <= gcnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rd_en;
            leds_q     <= leds_d;
        end
    end
endmodule

// File: tb/tb_led_pwm_engine.sv
// tb_led_pwm_engine: randomized and directed bench for led_pwm_engine against a period-arithmetic reference model
module tb_led_pwm_engine;
    localparam int NCH = 6;
    localparam int P   = 2;
    localparam int NL  = (NCH + 3) / 4;
    localparam int PER = 256 * P;
`ifdef LED_FADE_EN
    localparam logic [7:0] FEXP = 8'h33;
`else
    localparam logic [7:0] FEXP = 8'h00;
`endif

    logic           clk = 1'b0, reset_n = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0]     addr = 8'h00, wdata = 8'h00;
    logic [7:0]     rdata;
    logic           rvalid;
    logic [NCH-1:0] leds;
    int             n_chk = 0, n_err = 0;

    int             m_ac, m_wr;
    logic           m_sleep, m_dmb, m_inv;
    logic [7:0]     m_grppwm, m_grpfreq;
    logic [7:0]     m_lo [NL];
    logic [7:0]     m_pwm [NCH];
`ifdef LED_FADE_EN
    logic [7:0]     m_fstep;
    int             m_duty [NCH];
`endif
    logic [7:0]     e_rdata;
    logic           e_rvalid;
    logic [NCH-1:0] e_leds;
    int             c0, c1;

    led_pwm_engine #(.NUM_CH(NCH), .PWM_BITS(8), .PRESCALE(P)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .leds(leds)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ac = 0; m_wr = 0; m_sleep = 0; m_dmb = 0; m_inv = 0;
        m_grppwm = 0; m_grpfreq = 0; e_rdata = 0; e_rvalid = 0; e_leds = '0;
        for (int k = 0; k < NL; k++) m_lo[k] = 0;
        for (int i = 0; i < NCH; i++) m_pwm[i] = 0;
`ifdef LED_FADE_EN
        m_fstep = 0;
        for (int i = 0; i < NCH; i++) m_duty[i] = 0;
`endif
    endtask

    function automatic int eff(input int ch);
`ifdef LED_FADE_EN
        return m_fstep == 0 ? int'(m_pwm[ch]) : m_duty[ch];
`else
        return int'(m_pwm[ch]);
`endif
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a == 8'h00) return {3'b000, m_sleep, m_dmb, m_inv, 2'b00};
        if (a == 8'h01) return m_grppwm;
        if (a == 8'h02) return m_grpfreq;
`ifdef LED_FADE_EN
        if (a == 8'h03) return m_fstep;
`endif
        if (int'(a) >= 8 && int'(a) < 8 + NL) return m_lo[int'(a) - 8];
        if (int'(a) >= 32 && int'(a) < 32 + NCH) return m_pwm[int'(a) - 32];
        return 8'h00;
    endfunction

    // One clock edge of the reference: outputs from pre-edge state, then timebase, fade and register writes
    task automatic model_edge(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        int  cnt, gcnt, f, n;
        bit  wrap, hi, v;
        cnt  = (m_ac / P) % 256;
        gcnt = m_dmb ? (m_wr / (int'(m_grpfreq) + 1)) % 256 : m_wr % 256;
        for (int ch = 0; ch < NCH; ch++) begin
            f  = (int'(m_lo[ch / 4]) >> (2 * (ch % 4))) & 3;
            hi = cnt < eff(ch);
            v  = f == 1 ? 1'b1 : f == 2 ? hi : f == 3 ? (hi && gcnt < int'(m_grppwm)) : 1'b0;
            e_leds[ch] = m_sleep ? 1'b0 : v ^ m_inv;
        end
        e_rvalid = r;
        if (r) e_rdata = m_read(a);
        wrap = !m_sleep && ((m_ac + 1) % PER == 0);
        if (!m_sleep) m_ac++;
        if (wrap) m_wr++;
`ifdef LED_FADE_EN
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_fstep == 0) m_duty[ch] = m_pwm[ch];
            else if (wrap && m_pwm[ch] > m_duty[ch]) m_duty[ch] = (m_duty[ch] + m_fstep > m_pwm[ch]) ? m_pwm[ch] : m_duty[ch] + m_fstep;
            else if (wrap) m_duty[ch] = (m_duty[ch] - m_fstep < m_pwm[ch]) ? m_pwm[ch] : m_duty[ch] - m_fstep;
        end
`endif
        if (w) begin
            if (a == 8'h00) begin
                if (d[3] != m_dmb) m_wr = 0;
                {m_sleep, m_dmb, m_inv} = d[4:2];
            end
            if (a == 8'h01) m_grppwm = d;
            if (a == 8'h02) begin m_grpfreq = d; m_wr = 0; end
`ifdef LED_FADE_EN
            if (a == 8'h03) m_fstep = d;
`endif
            if (int'(a) >= 8 && int'(a) < 8 + NL) begin
                n = NCH - 4 * (int'(a) - 8);
                if (n > 4) n = 4;
                m_lo[int'(a) - 8] = d & 8'((1 << (2 * n)) - 1);
            end
            if (int'(a) >= 32 && int'(a) < 32 + NCH) m_pwm[int'(a) - 32] = d;
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        @(posedge clk);
        model_edge(w, r, a, d);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        check("leds", 32'(leds), 32'(e_leds));
        check("rvalid", 32'(rvalid), 32'(e_rvalid));
        if (e_rvalid) check("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d); step(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [7:0] a); step(1'b0, 1'b1, a, 8'h00); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00); endtask

    task automatic count_hi(input int n, output int h0, output int h1);
        h0 = 0; h1 = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            h0 += int'(leds[0]);
            h1 += int'(leds[1]);
        end
    endtask

    logic [7:0] alist [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09, 8'h0A, 8'h20,
                               8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h7F, 8'hFF};

    initial begin
        logic [7:0] a, d;
        int op;
        #1 reset_n = 1'b0;
        #1;
        check("rst_leds", 32'(leds), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        wr(8'h08, 8'h55); wr(8'h09, 8'h55); idle(3);
        check("all_on", 32'(leds), 32'h3F);
        wr(8'h00, 8'h04); idle(2);
        check("all_on_inv", 32'(leds), 0);
        wr(8'h00, 8'h00);
        rd(8'h09); check("ledout1_trunc", 32'(rdata), 32'h05);

        wr(8'h20, 8'h11); step(1'b1, 1'b1, 8'h20, 8'h22);
        check("rw_same", 32'(rdata), 32'h11);
        rd(8'h20); check("rw_after", 32'(rdata), 32'h22);
        rd(8'h7F); check("unmapped", 32'(rdata), 0);
        wr(8'h03, 8'h33); rd(8'h03); check("fadestep_rd", 32'(rdata), 32'(FEXP));
        wr(8'h03, 8'h00);

        wr(8'h08, 8'hAA); wr(8'h20, 8'h40); wr(8'h21, 8'h80);
        count_hi(PER, c0, c1);
        check("duty40", c0, 64 * P); check("duty80", c1, 128 * P);
        wr(8'h20, 8'h00); wr(8'h21, 8'hFF);
        count_hi(PER, c0, c1);
        check("duty00", c0, 0); check("dutyFF", c1, 255 * P);

        wr(8'h22, 8'h5A); wr(8'h00, 8'h14); idle(20);
        check("sleep_inv", 32'(leds), 0);
        rd(8'h22); check("sleep_rd", 32'(rdata), 32'h5A); check("sleep_rvalid", 32'(rvalid), 1);
        wr(8'h00, 8'h00); idle(5);

        wr(8'h08, 8'hFF); wr(8'h09, 8'h0F);
        for (int i = 0; i < NCH; i++) wr(8'(32 + i), 8'hFF);
        wr(8'h01, 8'h03); wr(8'h00, 8'h08); wr(8'h02, 8'h00); idle(1);
        for (int i = 0; i < PER && (m_ac % PER) != 0; i++) idle(1);
        for (int p = 0; p < 4; p++) begin
            count_hi(PER, c0, c1);
            check($sformatf("grp_period%0d", p), c0, p < 2 ? 255 * P : 0);
        end

`ifdef LED_FADE_EN
        wr(8'h08, 8'h02); wr(8'h20, 8'h00); idle(2);
        wr(8'h03, 8'h10); wr(8'h20, 8'h80);
        idle(8 * PER);
        count_hi(PER, c0, c1); check("fade_80", c0, 128 * P);
        wr(8'h20, 8'hF5);
        idle(8 * PER);
        count_hi(PER, c0, c1); check("fade_F5", c0, 245 * P);
        wr(8'h03, 8'h00);
`endif

        for (int i = 0; i < 3000; i++) begin
            a  = alist[$urandom_range(15, 0)];
            d  = 8'($urandom);
            op = int'($urandom_range(9, 0));
            if (a == 8'h00 && $urandom_range(3, 0) != 0) d[4] = 1'b0;
            if (a == 8'h02) d = d & 8'h03;
            step(op < 3, op >= 2 && op < 6, a, d);
        end

        rd_en = 1'b1; addr = 8'h20;
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_rvalid", 32'(rvalid), 0);
        check("midrst_leds", 32'(leds), 0);
        check("midrst_rdata", 32'(rdata), 0);
        @(negedge clk);
        rd_en = 1'b0; reset_n = 1'b1;
        model_reset();
        idle(3);
        rd(8'h20); check("post_rst_pwm0", 32'(rdata), 0);
        rd(8'h00); check("post_rst_mode", 32'(rdata), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/led_pwm_engine.md
LED_PWM_ENGINE -- requirements
Module: led_pwm_engine

Interface
REQ-001 Parameter NUM_CH, default 8, number of LED channels (1..16).
REQ-002 Parameter PWM_BITS, default 8, PWM counter and duty width (fixed 8 in register map).
REQ-003 Parameter PRESCALE, default 4, clk cycles per PWM counter tick (>=1).
REQ-004 Port clk  input  1  single clock, rising edge.
REQ-005 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 Port wr_en  input  1  register write strobe, one cycle.
REQ-007 Port rd_en  input  1  register read strobe, one cycle.
REQ-008 Port addr  input  8  register address.
REQ-009 Port wdata  input  8  write data.
REQ-010 Port rdata  output  8  read data, valid when rvalid=1.
REQ-011 Port rvalid  output  1  read-data qualifier.
REQ-012 Port leds  output  NUM_CH  LED drive, bit i = channel i.

Function
REQ-013 Register map: MODE 0x00 (bit4 SLEEP, bit3 DMBLNK, bit2 INVRT), GRPPWM 0x01, GRPFREQ 0x02, FADESTEP 0x03, LEDOUTk 0x08+k (k < ceil(NUM_CH/4), 2 bits per channel, ch 4k in bits 1:0), PWMi 0x20+i.
REQ-014 Write shall take effect on the clk edge where wr_en=1; writes to unmapped addresses and reserved MODE bits are ignored.
REQ-015 Read shall return rdata with rvalid=1 exactly one cycle after rd_en; unmapped addresses read 0x00; rvalid=0 otherwise.
REQ-016 Simultaneous rd_en and wr_en to the same address shall return the pre-write value.
REQ-017 PWM counter shall increment every PRESCALE clk cycles and wrap 255->0; a wrap marks one PWM period.
REQ-018 Channel PWM signal shall be high when counter < effective duty; duty 0x00 always low, 0xFF high 255/256.
REQ-019 LEDOUT field 00 = off, 01 = fully on, 10 = individual PWM, 11 = individual PWM AND group gate.
REQ-020 Group counter (8-bit) shall advance once per PWM period when DMBLNK=0, and once per (GRPFREQ+1) PWM periods when DMBLNK=1; group gate high when group counter < GRPPWM.
REQ-021 Writing MODE.DMBLNK or GRPFREQ shall clear the group counter and its prescaler.
REQ-022 INVRT=1 shall invert every leds bit after mode selection.
REQ-023 SLEEP=1 shall force leds to all 0 regardless of INVRT, hold all counters, and keep the register interface operational; clearing SLEEP resumes counting from held values.
REQ-024 Channels i >= NUM_CH shall not exist; LEDOUT fields beyond NUM_CH read 0.

Reset
REQ-025 reset_n low shall asynchronously clear all registers, counters, effective duties, rdata, rvalid and leds to 0.
REQ-026 Reset released mid-transaction shall discard any pending read (no rvalid pulse).

Configuration
REQ-027 Macro LED_FADE_EN, when defined, shall move each channel's effective duty toward PWMi by FADESTEP at every PWM wrap, saturating exactly at target; FADESTEP=0 means immediate update.
REQ-028 Without LED_FADE_EN, effective duty shall equal PWMi from the cycle after the write, FADESTEP shall read 0x00 and writes to it are ignored.

Verification
REQ-029 Reset, LEDOUT0=0x55, NUM_CH=4 -> leds=0xF continuously; INVRT=1 -> leds=0x0.
REQ-030 LEDOUT0=0xAA, PWM0=0x40, PWM1=0x80, PRESCALE=1 -> leds[0] high 64 of 256 cycles, leds[1] 128 of 256.
REQ-031 LEDOUT0=0xFF, all PWM=0xFF, GRPPWM=0x80, DMBLNK=1, GRPFREQ=0 -> leds high only during first 128 of each 256 PWM periods.
REQ-032 LED_FADE_EN, FADESTEP=0x10, PWM0 0x00->0x80 -> effective duty reaches 0x80 after exactly 8 PWM wraps; reaches 0xF5 target (from 0x80) saturating at 0xF5, not 0x100.
REQ-033 SLEEP=1 with INVRT=1 -> leds=0; read of PWM2 during sleep returns written value with rvalid one cycle after rd_en.
REQ-034 Read of 0x7F -> rdata=0x00; write+read same cycle to PWM0 (old 0x11, new 0x22) -> rdata=0x11, next read 0x22.
